taxi_pdec: RTL

Index-to-one-hot request dispatcher: the decode-side counterpart of the priority encoder. It accepts a stream of binary destination indices over a valid/ready handshake, buffers them in a 2-entry skid FIFO, and drives a registered one-hot request to the selected destination. Each request is held until that destination acknowledges or a timeout expires. It sits between an arbitration/scheduling stage that produces indices and a bank of WIDTH per-lane consumers.

---
 rtl/taxi_pdec_pkg.sv | 15 +
 rtl/taxi_pdec_skid.sv | 61 ++++++
 rtl/taxi_pdec.sv | 111 +++++++++++
 3 files changed

// File: rtl/taxi_pdec_pkg.sv
// taxi_pdec_pkg: shared definitions for the index-to-one-hot dispatcher.
//   state_t : dispatcher FSM states (IDLE, REQ)
//   idx_w() : bit width needed to hold a binary index into n items (min 1)
package taxi_pdec_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/taxi_pdec_skid.sv
// taxi_pdec_skid: 2-entry FIFO with a registered occupancy count.
//   clk, rst_n        : clock, synchronous active-low reset (pointers/count only)
//   s_data/s_valid    : write side; s_ready = count < 2 (registered count only)
//   m_data/m_valid    : head of queue; when empty the write side is bypassed
//   m_ready           : pop the head this cycle
//   count             : registered occupancy (0..2)
module taxi_pdec_skid #(
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              empty;
    logic              push;
    logic              pop;
    logic              store;
    logic              drain;

    assign empty   = (count == 2'd0);
    assign s_ready = (count != 2'd2);
    assign push    = s_valid && s_ready;

    // When empty the incoming word is presented directly at the head so the
    // consumer can take it in the same cycle it is accepted.
    assign m_valid = !empty || s_valid;
    assign m_data  = empty ? s_data : mem[rd_ptr];
    assign pop     = m_valid && m_ready;

    // A bypassed word passes straight through and never touches storage.
    assign store = push && !(empty && pop);
    assign drain = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (store) wr_ptr <= !wr_ptr;
            if (drain) rd_ptr <= !rd_ptr;
            count <= count + {1'b0, store} - {1'b0, drain};
        end
    end

    // Storage carries data only; it needs no reset.
    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= s_data;
    end

endmodule

// File: rtl/taxi_pdec.sv
// taxi_pdec: index-to-one-hot request dispatcher.
//   clk, rst_n          : clock, synchronous active-low reset
//   s_index/s_valid/s_ready : incoming destination index stream
//   m_req               : registered one-hot request (0 when idle)
//   m_index             : binary index of the asserted m_req bit (0 when idle)
//   m_ack               : per-destination acknowledge; only m_ack[m_index] counts
//   err_range           : pulse, head index >= WIDTH was dropped
//   err_timeout         : pulse, current request abandoned after TIMEOUT cycles
//   busy                : request outstanding or commands queued
module taxi_pdec
    import taxi_pdec_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [idx_w(WIDTH)-1:0]    s_index,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [WIDTH-1:0]           m_req,
    output logic [idx_w(WIDTH)-1:0]    m_index,
    input  logic [WIDTH-1:0]           m_ack,
    output logic                       err_range,
    output logic                       err_timeout,
    output logic                       busy
);

    localparam int IW = idx_w(WIDTH);
    localparam int TW = idx_w(TIMEOUT + 1);
    localparam logic [IW:0] WIDTH_V = (IW + 1)'(WIDTH);

    state_t          state;
    logic [TW-1:0]   timer;
    logic [IW-1:0]   head_idx;
    logic            head_valid;
    logic            head_pop;
    logic            head_bad;
    logic            head_good;
    logic [1:0]      fifo_count;
    logic            ack_hit;
    logic            to_hit;
    logic            done;
    logic            load;

    taxi_pdec_skid #(
        .DATA_W (IW)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (s_index),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (head_idx),
        .m_valid (head_valid),
        .m_ready (head_pop),
        .count   (fifo_count)
    );

    // Out-of-range entries are discarded as soon as they reach the head so
    // they can never stall the queue behind an outstanding request.
    assign head_bad  = head_valid && ({1'b0, head_idx} >= WIDTH_V);
    assign head_good = head_valid && !head_bad;

    // m_req is one-hot on m_index, so masking isolates the relevant ack bit.
    assign ack_hit = (state == REQ) && |(m_ack & m_req);
    assign to_hit  = (TIMEOUT > 0) && (state == REQ) && (timer == TW'(TIMEOUT - 1));
    assign done    = ack_hit || to_hit;
    assign load    = head_good && ((state == IDLE) || done);
    assign head_pop = head_bad || load;

    assign err_range   = rst_n && head_bad;
    assign err_timeout = rst_n && to_hit && !ack_hit;
    assign busy        = (m_req != '0) || (fifo_count != 2'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            m_req   <= '0;
            m_index <= '0;
            timer   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state   <= REQ;
                        m_req   <= WIDTH'(1) << head_idx;
                        m_index <= head_idx;
                        timer   <= '0;
                    end
                end
                REQ: begin
                    if (load) begin
                        m_req   <= WIDTH'(1) << head_idx;
                        m_index <= head_idx;
                        timer   <= '0;
                    end else if (done) begin
                        state   <= IDLE;
                        m_req   <= '0;
                        m_index <= '0;
                        timer   <= '0;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
